// File: rtl/bus_pkg.sv
// Shared bus constants and arbiter state encoding, used by the arbiter, mux and datapath.
package bus_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first set bit of i_vec at or above i_base, wrapping 7->0.
// Purely combinational.
module rr_pick
  import bus_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  input  logic [SEL_W-1:0] i_base,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  logic [SEL_W-1:0] w_pos;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Index arithmetic is SEL_W bits wide, so the wrap falls out of the overflow.
      w_pos = i_base + k[SEL_W-1:0];
      if (!o_found && i_vec[w_pos]) begin
        o_idx   = w_pos;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// 8-way round-robin bus arbiter with a bounded tenure while others wait.
// Decisions in cycle t appear on grant/key/bus_en in cycle t+1; handovers have no idle bubble.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] key,
  output logic             bus_en
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_HOLD);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [SEL_W-1:0] r_key, w_key_nxt;
  logic             r_bus_en;

  logic [N_REQ-1:0] w_pick_vec;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_found;
  logic             w_owner_req;
  logic             w_take;

  // ptr is always owner+1 while OWNED, so one picker serves both states;
  // only the owner bit needs masking when looking for a successor.
  assign w_pick_vec  = (r_state == ST_OWNED) ? (req & ~r_grant) : req;
  assign w_owner_req = |(req & r_grant);

  rr_pick u_pick (
    .i_vec   (w_pick_vec),
    .i_base  (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_key_nxt   = r_key;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_take = 1'b1;
        end else begin
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      ST_OWNED: begin
        if (!w_owner_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end else if (r_cnt < LP_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_found) begin
          w_take = 1'b1;
        end else begin
          w_cnt_nxt = LP_MAX;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    if (w_take) begin
      w_state_nxt = ST_OWNED;
      w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
      w_key_nxt   = w_pick_idx;
      w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
      w_ptr_nxt   = w_pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_key    <= '0;
      r_bus_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
      r_key    <= w_key_nxt;
      r_bus_en <= |w_grant_nxt;
    end
  end

  assign grant  = r_grant;
  assign key    = r_key;
  assign bus_en = r_bus_en;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, SHALL set the maximum consecutive grant cycles while another requester waits; legal range 1..15.
REQ-002 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high.
REQ-004 req  input  8  SHALL carry one bus request per requester; bit i = requester i, the source wired to mux input i.
REQ-005 grant  output  8  SHALL be one-hot or zero; bit i = requester i currently owns the bus.
REQ-006 key  output  3  SHALL be the binary index of the current owner, driving the select of the 8:1 16-bit bus mux.
REQ-007 bus_en  output  1  SHALL be high exactly when grant is non-zero, to qualify the mux output at the bus sink.

Function
REQ-008 All outputs SHALL be registered; a decision made in cycle t SHALL appear on grant/key/bus_en in cycle t+1.
REQ-009 FSM SHALL have two states: IDLE (no owner) and OWNED (one owner).
REQ-010 IDLE: with req != 0, the winner SHALL be the first set bit searching upward from ptr with wrap 7->0; go to OWNED, tenure counter = 1.
REQ-011 IDLE: with req == 0, the block SHALL stay in IDLE with grant = 0 and bus_en = 0.
REQ-012 OWNED, req[owner] = 0 (release): the next winner SHALL be the first set bit of req with the owner bit masked, searching from owner+1 with wrap; if none, go to IDLE.
REQ-013 OWNED, req[owner] = 1, counter < MAX_HOLD: the owner SHALL keep the grant and the counter SHALL increment.
REQ-014 OWNED, req[owner] = 1, counter = MAX_HOLD, another bit set: grant SHALL move to the next requester per REQ-012 (preemption); counter = 1.
REQ-015 OWNED, counter = MAX_HOLD, no other bit set: the owner SHALL keep the grant and the counter SHALL saturate at MAX_HOLD.
REQ-016 Ownership changes SHALL take effect with no idle bubble; the old grant bit and the new grant bit SHALL switch in the same edge.
REQ-017 On every grant to requester i, ptr SHALL be set to (i+1) mod 8.
REQ-018 key SHALL hold the last owner index while IDLE; only grant/bus_en indicate validity.
REQ-019 The counter SHALL be 4 bits wide and SHALL never exceed MAX_HOLD.
REQ-020 grant SHALL never have more than one bit set.

Reset
REQ-021 While reset is high at a clock edge: state = IDLE, grant = 0, key = 0, bus_en = 0, ptr = 0, counter = 0.
REQ-022 Reset SHALL override any simultaneous req activity and SHALL abort an ownership mid-tenure with no residual priority.
REQ-023 The first edge after reset deasserts SHALL arbitrate normally from ptr = 0.

Structure
REQ-024 Shared package bus_pkg SHALL hold N_REQ = 8, SEL_W = 3, CNT_W = 4 and the IDLE/OWNED state encoding; bus_pkg is shared with the mux and datapath.
REQ-025 The rotating priority search SHALL be one sub-module, rr_pick (inputs: 8-bit vector and 3-bit base; outputs: index and found); it SHALL be combinational.
REQ-026 bus_arbiter SHALL contain the FSM, counter, ptr and output registers only.

Verification
REQ-027 Reset, then req = 8'h00 for 5 cycles -> grant = 0, bus_en = 0, key = 0 throughout.
REQ-028 req = 8'h24 from IDLE with ptr = 0 -> next cycle grant = 8'h04, key = 2; requester 2 drops req -> next cycle grant = 8'h20, key = 5, no bubble.
REQ-029 MAX_HOLD = 4, req = 8'h03 held constant -> grant alternates 01,01,01,01,02,02,02,02,01,...
REQ-030 MAX_HOLD = 4, req = 8'h80 alone for 10 cycles -> grant = 8'h80 for all cycles, counter saturates at 4.
REQ-031 Owner 3 with req = 8'h89 at counter = 4 -> next grant = 8'h80 (search from 4), then 8'h01 after its tenure ends.
REQ-032 Reset asserted during OWNED with counter = 2 -> next cycle all outputs zero; a later req = 8'hFF gives grant = 8'h01.
